// File: rtl/act_loader_pkg.sv
// Shared types and constants for the activation stream loader.
package act_loader_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;
    localparam int FIFO_IDX_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/act_loader_fifo.sv
// Two-entry FIFO with first-word fall-through: a word pushed into an empty FIFO
// is visible at the head in the same cycle, so the loader sustains 1 word/cycle.
module act_loader_fifo
    import act_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_W-1:0]     mem [FIFO_DEPTH];
    logic [FIFO_IDX_W-1:0] wr_idx;
    logic [FIFO_IDX_W-1:0] rd_idx;
    logic [FIFO_CNT_W-1:0] cnt;
    logic                  bypass;

    // Push and pop on an empty FIFO pass the word straight through without storing it.
    assign bypass = (cnt == '0) && push && pop;
    assign empty  = (cnt == '0) && !push;
    assign head   = (cnt == '0) ? push_data : mem[rd_idx];
    assign count  = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !bypass) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= wr_idx + FIFO_IDX_W'(1);
            end
            if (pop && !bypass) begin
                rd_idx <= rd_idx + FIFO_IDX_W'(1);
            end
            cnt <= cnt + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

endmodule

// File: rtl/act_stream_loader.sv
// Streams N activation words from a source buffer into a layer input buffer.
// Optional macro ACT_LOADER_RELU_EN clamps negative words to zero on the write port.
//
// state     | meaning
// ST_IDLE   | waiting for sm_start
// ST_STREAM | issuing source reads and draining the FIFO into the destination
// ST_FINISH | one-cycle done pulse, then back to idle
module act_stream_loader
    import act_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sm_start,
    input  logic              sel,
    input  logic [ADDR_W:0]   num_words,
    output logic              src_ren,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_rdata,
    output logic              dst_wen,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_wdata,
    output logic              dst_sel,
    input  logic              dst_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_W:0]       n_q;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       wr_ptr;
    logic                  sel_q;
    logic                  in_flight;
    logic                  issue;
    logic                  start_acc;
    logic                  pop;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [2:0]            occ_sum;
    logic [DATA_W-1:0]     wdata_mod;

    act_loader_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data (src_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pop     = !fifo_empty && dst_ready;
    // Occupancy the FIFO will hold after this cycle; a new read is issued only if it leaves room.
    assign occ_sum = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

`ifdef ACT_LOADER_RELU_EN
    assign wdata_mod = fifo_head[DATA_W-1] ? '0 : fifo_head;
`else
    assign wdata_mod = fifo_head;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sm_start) begin
                    start_acc = 1'b1;
                    state_nxt = (num_words == '0) ? ST_FINISH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                issue = (rd_ptr < n_q) && (occ_sum < 3'd2);
                if (pop && ((wr_ptr + PTR_ONE) == n_q)) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            sel_q     <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (start_acc) begin
                n_q    <= num_words;
                sel_q  <= sel;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (issue) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (pop) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
        end
    end

    // Address and data buses are forced to zero whenever their strobe is low.
    assign src_ren   = issue;
    assign src_addr  = issue ? rd_ptr[ADDR_W-1:0] : '0;
    assign dst_wen   = !fifo_empty;
    assign dst_addr  = dst_wen ? wr_ptr[ADDR_W-1:0] : '0;
    assign dst_wdata = dst_wen ? wdata_mod : '0;
    assign dst_sel   = sel_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FINISH);

endmodule

// File: tb/tb_act_stream_loader.sv
// Scoreboard bench for act_stream_loader; honours ACT_LOADER_RELU_EN when defined.
module tb_act_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sm_start = 1'b0;
    logic        sel = 1'b0;
    logic [8:0]  num_words = '0;
    logic        src_ren;
    logic [7:0]  src_addr;
    logic [31:0] src_rdata = '0;
    logic        dst_wen;
    logic [7:0]  dst_addr;
    logic [31:0] dst_wdata;
    logic        dst_sel;
    logic        dst_ready = 1'b1;
    logic        busy;
    logic        done;

    act_stream_loader #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .sm_start(sm_start), .sel(sel), .num_words(num_words),
        .src_ren(src_ren), .src_addr(src_addr), .src_rdata(src_rdata),
        .dst_wen(dst_wen), .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_sel(dst_sel),
        .dst_ready(dst_ready), .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        sel;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_rd[$];
    logic [31:0] src_mem [256];
    logic [31:0] wr_log  [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int k_cur   = 0;

    int ren_cnt, first_ren, last_ren;
    int wen_cnt, first_wen, last_wen, wr_cnt;
    int done_cnt, done_cyc;

    int ready_mode = 0;
    int stall_lo = 0, stall_hi = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] w);
`ifdef ACT_LOADER_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source buffer: data valid exactly one cycle after the read strobe.
    initial begin
        logic       r;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            r = src_ren;
            a = src_addr;
            @(posedge clk);
            #1;
            src_rdata = r ? src_mem[a] : $urandom;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       dst_ready = 1'b1;
            1:       dst_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            default: dst_ready = ($urandom_range(0, 99) < 70);
        endcase
    end

    // Monitor: compares every read issue and accepted write against the scoreboard.
    initial begin
        logic        prev_stall;
        logic [7:0]  prev_addr;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (src_ren) begin
                    ren_cnt++;
                    if (first_ren < 0) first_ren = cyc;
                    last_ren = cyc;
                    if (exp_rd.size() > 0) check("src_addr", src_addr, exp_rd.pop_front());
                end
                if (dst_wen) begin
                    wen_cnt++;
                    if (first_wen < 0) first_wen = cyc;
                    last_wen = cyc;
                    if (prev_stall) begin
                        check("stall_hold_addr", dst_addr, prev_addr);
                        check("stall_hold_data", dst_wdata, prev_data);
                    end
                    if (dst_ready) begin
                        wr_cnt++;
                        wr_log[dst_addr] = dst_wdata;
                        if (exp_wr.size() > 0) begin
                            wr_t e;
                            e = exp_wr.pop_front();
                            check("dst_addr", dst_addr, e.addr);
                            check("dst_wdata", dst_wdata, e.data);
                            check("dst_sel", dst_sel, e.sel);
                        end
                    end
                end else if (prev_stall) begin
                    check("stall_hold_wen", dst_wen, 1);
                end
                prev_stall = dst_wen && !dst_ready;
                prev_addr  = dst_addr;
                prev_data  = dst_wdata;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_stats();
        ren_cnt = 0; first_ren = -1; last_ren = -1;
        wen_cnt = 0; first_wen = -1; last_wen = -1; wr_cnt = 0;
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic start_xfer(input int n, input logic s);
        wr_t e;
        @(posedge clk);
        #1;
        clear_stats();
        exp_wr.delete();
        exp_rd.delete();
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(i % 256);
            e.addr = 8'(i);
            e.data = model(src_mem[i % 256]);
            e.sel  = s;
            exp_wr.push_back(e);
        end
        sm_start  = 1'b1;
        sel       = s;
        num_words = 9'(n);
        k_cur     = cyc;
        @(posedge clk);
        #1;
        sm_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        check("done_seen", (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input int n);
        check("done_count", done_cnt, 1);
        check("write_count", wr_cnt, n);
        check("read_count", ren_cnt, n);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("busy_after", busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_src_ren"}, src_ren, 0);
        check({tag, "_dst_wen"}, dst_wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dst_sel"}, dst_sel, 0);
        check({tag, "_src_addr"}, src_addr, 0);
        check({tag, "_dst_addr"}, dst_addr, 0);
        check({tag, "_dst_wdata"}, dst_wdata, 0);
    endtask

    initial begin
        int n;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // N=4, source data = address + 100, unstalled.
        for (int i = 0; i < 256; i++) src_mem[i] = 32'(i + 100);
        ready_mode = 0;
        start_xfer(4, 1'b0);
        wait_done(40);
        end_checks(4);
        check("n4_first_ren", first_ren, k_cur + 1);
        check("n4_last_ren", last_ren, k_cur + 4);
        check("n4_first_wen", first_wen, k_cur + 2);
        check("n4_last_wen", last_wen, k_cur + 5);
        check("n4_done_cyc", done_cyc, k_cur + 6);
        for (int i = 0; i < 4; i++) check("n4_data", wr_log[i], 32'(i + 100));

        // N=6 with destination stalled for cycles k+3..k+5.
        for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
        @(posedge clk);
        #1;
        stall_lo = cyc + 4;
        stall_hi = cyc + 6;
        ready_mode = 1;
        start_xfer(6, 1'b1);
        wait_done(60);
        end_checks(6);
        check("stall_window_k", stall_lo, k_cur + 3);
        check("n6_wen_cycles", wen_cnt, 9);
        check("n6_done_cyc", done_cyc, k_cur + 11);
        ready_mode = 0;

        // N=0: immediate completion, no traffic.
        start_xfer(0, 1'b0);
        wait_done(20);
        end_checks(0);
        check("n0_done_cyc", done_cyc, k_cur + 1);
        check("n0_wen_cycles", wen_cnt, 0);

        // Second start while busy must be ignored.
        start_xfer(5, 1'b1);
        @(posedge clk);
        #1;
        sm_start  = 1'b1;
        sel       = 1'b0;
        num_words = 9'd3;
        @(posedge clk);
        #1;
        sm_start = 1'b0;
        wait_done(40);
        repeat (4) @(posedge clk);
        #1;
        end_checks(5);
        check("restart_done_cyc", done_cyc, k_cur + 7);
        check("restart_dst_sel", dst_sel, 1);

        // Reset in the middle of an N=8 transfer, then a fresh N=2 transfer.
        start_xfer(8, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_at_k3", cyc, k_cur + 3);
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_wr.delete();
        exp_rd.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
        start_xfer(2, 1'b0);
        wait_done(30);
        end_checks(2);
        check("post_abort_done_cyc", done_cyc, k_cur + 4);

        // Sign handling of the write data.
        src_mem[0] = 32'hFFFF_FFF0;
        src_mem[1] = 32'h0000_0010;
        start_xfer(2, 1'b0);
        wait_done(30);
        end_checks(2);
`ifdef ACT_LOADER_RELU_EN
        check("relu_neg", wr_log[0], 32'h0000_0000);
`else
        check("relu_neg", wr_log[0], 32'hFFFF_FFF0);
`endif
        check("relu_pos", wr_log[1], 32'h0000_0010);
        check("relu_done_cyc", done_cyc, k_cur + 4);

        // Randomized transfers, including N=1 and the full 2^ADDR_W length.
        for (int t = 0; t < 10; t++) begin
            logic s;
            n = (t == 0) ? 1 : (t == 1) ? 256 : $urandom_range(1, 24);
            for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
            s = 1'($urandom_range(0, 1));
            ready_mode = (t == 1) ? 0 : 2;
            start_xfer(n, s);
            wait_done(n * 12 + 40);
            end_checks(n);
            if (t == 1) check("n256_done_cyc", done_cyc, k_cur + 258);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
